// File: rtl/link_arbiter_if.sv
// rtl/link_arbiter_if.sv - requester and transceiver handshake bundle for link_arbiter
// master is the arbiter side; slave is the requesters plus transmitter/receiver side.
interface link_arbiter_if #(
  parameter int LENW = 6
);
  logic [1:0]        req_valid;
  logic [15:0]       req_cmd;
  logic [2*LENW-1:0] req_len;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic              done_timeout;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [LENW-1:0]   rx_index;
  logic              send_en;
  logic [7:0]        send_cmd;
  logic              send_done;
  logic              rec_reset;
  logic              rec_en;
  logic              out_valid;
  logic [7:0]        rec_data;
  logic              timeout;

  modport master (
    input  req_valid, req_cmd, req_len, send_done, out_valid, rec_data, timeout,
    output grant, done, done_timeout, rx_data, rx_valid, rx_index,
           send_en, send_cmd, rec_reset, rec_en
  );

  modport slave (
    output req_valid, req_cmd, req_len, send_done, out_valid, rec_data, timeout,
    input  grant, done, done_timeout, rx_data, rx_valid, rx_index,
           send_en, send_cmd, rec_reset, rec_en
  );
endinterface

// File: rtl/link_arbiter.sv
// rtl/link_arbiter.sv - two-client round-robin owner of the serial send/receive transceiver pair
// One transaction at a time: arbitrate, send command, collect response or timeout, report, guard gap.
module link_arbiter #(
  parameter int LENW       = 6,
  parameter int GAP_CYCLES = 64,
  parameter int CNTW       = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  link_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SEND, S_WAIT_SEND, S_REC_RST, S_REC, S_DONE, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] gap_q, gap_d;
  logic            to_q, to_d;
  logic            send_done_q;
  logic            rx_valid_q;
  logic [7:0]      rx_data_q;
  logic [LENW-1:0] rx_index_q;

  logic win;
  logic send_rise;
  logic byte_take;
  logic last_byte;

  assign send_rise = bus.send_done & ~send_done_q;
  assign byte_take = (state_q == S_REC) & bus.out_valid;
  // A byte arriving with Timeout still counts, so completion wins over timeout.
  assign last_byte = byte_take & ((cnt_q + 1'b1) == len_q);

  always_comb begin
    case (bus.req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = rr_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) state_d = S_ARB;
      end
      S_ARB: begin
        grant_d = win ? 2'b10 : 2'b01;
        cmd_d   = win ? bus.req_cmd[15:8] : bus.req_cmd[7:0];
        len_d   = win ? bus.req_len[2*LENW-1:LENW] : bus.req_len[LENW-1:0];
        if (&bus.req_valid) rr_d = ~win;
        state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_SEND;
      end
      S_WAIT_SEND: begin
        if (send_rise) begin
          to_d    = 1'b0;
          state_d = (len_q == '0) ? S_DONE : S_REC_RST;
        end
      end
      S_REC_RST: begin
        cnt_d   = '0;
        state_d = S_REC;
      end
      S_REC: begin
        if (byte_take) cnt_d = cnt_q + 1'b1;
        if (last_byte) begin
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (bus.timeout) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        grant_d = 2'b00;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == CNTW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                                gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      grant_q     <= 2'b00;
      cmd_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      to_q        <= 1'b0;
      send_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_index_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
      send_done_q <= bus.send_done;
      rx_valid_q  <= byte_take;
      if (byte_take) begin
        rx_data_q  <= bus.rec_data;
        rx_index_q <= cnt_q;
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = (state_q == S_DONE) ? grant_q : 2'b00;
  assign bus.done_timeout = (state_q == S_DONE) & to_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_index     = rx_index_q;
  assign bus.send_en      = (state_q == S_SEND);
  assign bus.send_cmd     = cmd_q;
  assign bus.rec_reset    = (state_q == S_REC_RST);
  assign bus.rec_en       = (state_q == S_REC);

endmodule

// File: tb/tb_link_arbiter.sv
// tb/tb_link_arbiter.sv - randomized self-checking bench for link_arbiter
// Transmitter/receiver responder plus a transaction-level reference model.
module tb_link_arbiter;
  localparam int LENW = 6;
  localparam int GAP  = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  link_arbiter_if #(.LENW(LENW)) bus ();

  link_arbiter #(.LENW(LENW), .GAP_CYCLES(GAP), .CNTW(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {1'b0, bus.grant, bus.done, bus.done_timeout, bus.rx_data, bus.rx_valid,
            bus.rx_index, bus.send_en, bus.send_cmd, bus.rec_reset, bus.rec_en};
  endfunction

  // Reference model state: which client wins the next contested arbitration.
  int pref     = 0;
  int next_lat = 2;

  function automatic int pick(input int mask);
    if (mask == 1) return 0;
    if (mask == 2) return 1;
    return pref;
  endfunction

  logic [7:0] cfg_bytes[$];
  bit cfg_to = 0, cfg_to_same = 0, cfg_noise = 0, cfg_idle_noise = 0;
  int cfg_delay = 0;

  // Transmitter and receiver stand-in.
  initial begin
    bus.send_done = 1'b0;
    bus.out_valid = 1'b0;
    bus.rec_data  = 8'h00;
    bus.timeout   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_en === 1'b1) begin
        for (int i = 0; i <= cfg_delay; i++) begin
          bus.out_valid = cfg_noise ? 1'($urandom) : 1'b0;
          bus.timeout   = cfg_noise ? 1'($urandom) : 1'b0;
          bus.rec_data  = 8'($urandom);
          @(negedge clk);
        end
        bus.out_valid = 1'b0;
        bus.timeout   = 1'b0;
        bus.send_done = 1'b1;
        @(negedge clk);
        bus.send_done = 1'b0;
        if (cfg_bytes.size() > 0 || cfg_to) begin
          for (int k = 0; k < 20 && bus.rec_en !== 1'b1; k++) @(negedge clk);
          foreach (cfg_bytes[j]) begin
            bus.out_valid = 1'b1;
            bus.rec_data  = cfg_bytes[j];
            bus.timeout   = cfg_to_same && (j == cfg_bytes.size() - 1);
            @(negedge clk);
            bus.out_valid = 1'b0;
            bus.timeout   = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
          end
          if (cfg_to && !(cfg_to_same && cfg_bytes.size() > 0)) begin
            bus.timeout = 1'b1;
            @(negedge clk);
            bus.timeout = 1'b0;
          end
        end
      end else begin
        bus.out_valid = cfg_idle_noise ? 1'($urandom) : 1'b0;
        bus.rec_data  = 8'($urandom);
      end
    end
  end

  int n_send_en = 0, n_rec_rst = 0, n_rec_en = 0, n_done = 0, n_unowned = 0;
  logic [7:0] rx_q[$];
  int idx_q[$];

  initial forever begin
    @(negedge clk);
    if (bus.send_en === 1'b1)   n_send_en++;
    if (bus.rec_reset === 1'b1) n_rec_rst++;
    if (bus.rec_en === 1'b1)    n_rec_en++;
    if (bus.done != 2'b00)      n_done++;
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      idx_q.push_back(int'(bus.rx_index));
      if (bus.grant == 2'b00) n_unowned++;
    end
  end

  task automatic run_txn(input string tag, input int mask, input logic [7:0] c0, input logic [7:0] c1,
                         input int l0, input int l1, input int nb, input int base, input bit to,
                         input bit to_same, input int delay, input bit noise, input int extra_idle);
    int w, len, nfwd, lat, k, gl, rb, bs, br, be, bd, bu;
    bit exp_to;
    logic [7:0] sent[$];
    logic [7:0] wcmd;
    w = pick(mask);
    if (mask == 3) pref = 1 - w;
    len  = (w == 1) ? l1 : l0;
    wcmd = (w == 1) ? c1 : c0;
    for (int i = 0; i < nb; i++) sent.push_back((base >= 0) ? 8'(base + i) : 8'($urandom));
    nfwd   = (nb < len) ? nb : len;
    exp_to = (len > 0) && (nb < len);
    cfg_bytes = sent; cfg_to = to; cfg_to_same = to_same; cfg_delay = delay;
    cfg_noise = noise; cfg_idle_noise = 1'b0;
    bs = n_send_en; br = n_rec_rst; be = n_rec_en; bd = n_done; bu = n_unowned; rb = rx_q.size();
    bus.req_cmd   = {c1, c0};
    bus.req_len   = {LENW'(l1), LENW'(l0)};
    bus.req_valid = 2'(mask);
    lat = 0;
    while (bus.send_en !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(next_lat));
    check({tag, "_grant"}, 32'(bus.grant), 32'(1) << w);
    check({tag, "_send_cmd"}, 32'(bus.send_cmd), 32'(wcmd));
    bus.req_valid = 2'b00;
    k = 0;
    while (bus.done == 2'b00 && k < 3000) begin @(negedge clk); k++; end
    check({tag, "_done"}, 32'(bus.done), 32'(1) << w);
    check({tag, "_done_timeout"}, 32'(bus.done_timeout), 32'(exp_to));
    check({tag, "_grant_at_done"}, 32'(bus.grant), 32'(1) << w);
    check({tag, "_rec_en_at_done"}, 32'(bus.rec_en), 32'(0));
    cfg_idle_noise = noise;
    gl = 0;
    for (int i = 0; i < GAP; i++) begin @(negedge clk); if (bus.grant == 2'b00) gl++; end
    check({tag, "_gap_grant_low"}, 32'(gl), 32'(GAP));
    check({tag, "_rx_count"}, 32'(rx_q.size() - rb), 32'(nfwd));
    for (int i = 0; i < nfwd && rb + i < rx_q.size(); i++) begin
      check({tag, "_rx_data"}, 32'(rx_q[rb+i]), 32'(sent[i]));
      check({tag, "_rx_index"}, 32'(idx_q[rb+i]), 32'(i));
    end
    check({tag, "_send_en_pulses"}, 32'(n_send_en - bs), 32'(1));
    check({tag, "_rec_reset_pulses"}, 32'(n_rec_rst - br), 32'(len > 0));
    check({tag, "_rec_en_seen"}, 32'((n_rec_en - be) > 0), 32'(len > 0));
    check({tag, "_done_pulses"}, 32'(n_done - bd), 32'(1));
    check({tag, "_rx_unowned"}, 32'(n_unowned - bu), 32'(0));
    repeat (extra_idle) @(negedge clk);
    cfg_idle_noise = 1'b0;
    next_lat = (extra_idle > 0) ? 2 : 3;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    int mask, l0, l1, w, len, mode, nb, k, seen, prev, bd, rb, be;
    bit to, ts;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_cmd   = 16'h0000;
    bus.req_len   = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", out_vec(), 32'h0);
    next_lat = 2;

    run_txn("c0_basic", 1, 8'h01, 8'h77, 4, 2, 4, 'hA0, 1'b0, 1'b0, 100, 1'b0, 1);
    run_txn("c1_timeout", 2, 8'h10, 8'hFF, 5, 3, 1, -1, 1'b1, 1'b0, $urandom_range(0, 8), 1'b0, 1);
    run_txn("same_cycle", 1, 8'($urandom), 8'($urandom), 2, 1, 2, -1, 1'b0, 1'b1, 5, 1'b0, 0);
    run_txn("noise_a", 2, 8'($urandom), 8'($urandom), 3, 4, 4, -1, 1'b0, 1'b0, 10, 1'b1, 2);
    run_txn("noise_b", 1, 8'($urandom), 8'($urandom), 5, 1, 5, -1, 1'b0, 1'b0, 6, 1'b1, 1);

    // Both clients request continuously with zero-length responses.
    cfg_bytes.delete(); cfg_to = 0; cfg_to_same = 0; cfg_delay = 0; cfg_noise = 0;
    bus.req_cmd = {8'h22, 8'h11}; bus.req_len = '0; bus.req_valid = 2'b11;
    prev = n_send_en; be = n_rec_en; seen = 0;
    for (int c = 0; c < 1500 && seen < 4; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        w = pick(3);
        pref = 1 - w;
        check("alt_done_owner", 32'(bus.done), 32'(1) << w);
        check("alt_send_en_per_done", 32'(n_send_en - prev), 32'(1));
        prev = n_send_en;
        seen++;
      end
    end
    bus.req_valid = 2'b00;
    check("alt_done_count", 32'(seen), 32'(4));
    repeat (GAP + 1) @(negedge clk);
    check("alt_no_rec_en", 32'(n_rec_en - be), 32'(0));
    next_lat = 2;

    for (int t = 0; t < 10; t++) begin
      mask = $urandom_range(1, 3);
      l0 = $urandom_range(0, 5);
      l1 = $urandom_range(0, 5);
      w = pick(mask);
      len = (w == 1) ? l1 : l0;
      mode = $urandom_range(0, 2);
      to = 1'b0; ts = 1'b0;
      if (mode == 0) nb = len;
      else if (mode == 1) nb = len + 1;
      else begin
        nb = (len > 0) ? $urandom_range(0, len - 1) : 0;
        to = (len > 0);
      end
      if (mode != 1 && nb > 0) ts = 1'($urandom);
      run_txn($sformatf("rand%0d", t), mask, 8'($urandom), 8'($urandom), l0, l1, nb, -1, to, ts,
              $urandom_range(0, 20), 1'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a receive phase.
    cfg_bytes = '{8'h5A}; cfg_to = 0; cfg_to_same = 0; cfg_delay = 3; cfg_noise = 0;
    bus.req_cmd = {8'h00, 8'h33}; bus.req_len = {LENW'(0), LENW'(4)}; bus.req_valid = 2'b01;
    rb = rx_q.size();
    k = 0;
    while (rx_q.size() == rb && k < 400) begin @(negedge clk); k++; end
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("rst_mid_in_rec", 32'(bus.rec_en), 32'(1));
    check("rst_mid_grant", 32'(bus.grant), 32'(1));
    bd = n_done;
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", out_vec(), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pref = 0;
    next_lat = 2;
    run_txn("rst_both", 3, 8'h44, 8'h55, 1, 2, 1, -1, 1'b0, 1'b0, 2, 1'b0, 1);
    check("rst_no_done", 32'(n_done - bd), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
